// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the 4x4 keypad scan controller.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_KEYS = 16;

  localparam int unsigned KEY_P1_UP   = 1;
  localparam int unsigned KEY_P1_DOWN = 9;
  localparam int unsigned KEY_P2_UP   = 3;
  localparam int unsigned KEY_P2_DOWN = 11;

  typedef logic [1:0] row_idx_t;

  // Bit positions of the paddle pulse vector.
  typedef enum logic [1:0] {
    PadP1Up   = 2'd0,
    PadP1Down = 2'd1,
    PadP2Up   = 2'd2,
    PadP2Down = 2'd3
  } pad_e;

  function automatic logic [NUM_ROWS-1:0] row_onehot(row_idx_t idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Single-key debounce: the stable level flips after DEBOUNCE_SCANS consecutive
// differing samples, evaluated once per full scan (update_i).
module keypad_debounce #(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic update_i,
  input  logic raw_i,
  output logic stable_o,
  output logic stable_d_o,
  output logic rise_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (update_i) begin
      if (raw_i != stable_q) begin
        if (cnt_q == CntW'(DEBOUNCE_SCANS - 1)) begin
          stable_d = ~stable_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o   = stable_q;
  assign stable_d_o = stable_d;
  assign rise_o     = update_i & ~stable_q & stable_d;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner, per-key debounce and two-player paddle arbitration.
// Define KEYPAD_AUTOREPEAT_EN to add auto-repeat of held paddle keys.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES   = 1000,
  parameter int unsigned SETTLE_CYCLES  = 100,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [NUM_ROWS-1:0] row_o,
  input  logic [NUM_COLS-1:0] col_i,
  output logic [NUM_KEYS-1:0] key_state_o,
  output logic                scan_done_o,
  output logic                key_press_o,
  output logic [3:0]          key_code_o,
  output logic                p1_up_o,
  output logic                p1_down_o,
  output logic                p2_up_o,
  output logic                p2_down_o
);

  localparam int unsigned DwellW = $clog2(DWELL_CYCLES);

  if (DWELL_CYCLES < 2 || SETTLE_CYCLES >= DWELL_CYCLES || DEBOUNCE_SCANS < 1 ||
      REPEAT_SCANS < 1) begin : g_param_check
    $error("keypad_scan_ctrl: illegal parameter combination");
  end

  logic [DwellW-1:0]   dwell_q, dwell_d;
  row_idx_t            row_idx_q, row_idx_d;
  logic [NUM_KEYS-1:0] raw_q, raw_d;
  logic                scan_done_q, key_press_q;
  logic [3:0]          key_code_q, key_code_d;
  logic [3:0]          pad_q, pad_d;

  logic                scan_end;
  logic [NUM_KEYS-1:0] stable, stable_nxt, rise;
  logic [3:0]          low_idx;
  logic [3:0]          pad_rise, pad_nxt, conflict, rep_fire;
  logic                p1_conflict, p2_conflict;
  logic                unused_nxt;

  assign scan_end = (row_idx_q == 2'd3) && (dwell_q == DwellW'(DWELL_CYCLES - 1));

  always_comb begin
    dwell_d   = dwell_q + 1'b1;
    row_idx_d = row_idx_q;
    raw_d     = raw_q;
    if (dwell_q == DwellW'(DWELL_CYCLES - 1)) begin
      dwell_d   = '0;
      row_idx_d = row_idx_q + 1'b1;
    end
    if (dwell_q == DwellW'(SETTLE_CYCLES)) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        raw_d[{row_idx_q, 2'(c)}] = col_i[c];
      end
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    keypad_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .update_i  (scan_end),
      .raw_i     (raw_q[k]),
      .stable_o  (stable[k]),
      .stable_d_o(stable_nxt[k]),
      .rise_o    (rise[k])
    );
  end

  assign unused_nxt = ^stable_nxt;

  // Lowest rising index wins the key_code report.
  always_comb begin
    low_idx = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (rise[k]) low_idx = 4'(k);
    end
  end

  assign pad_rise = {rise[KEY_P2_DOWN], rise[KEY_P2_UP], rise[KEY_P1_DOWN], rise[KEY_P1_UP]};
  assign pad_nxt  = {stable_nxt[KEY_P2_DOWN], stable_nxt[KEY_P2_UP],
                     stable_nxt[KEY_P1_DOWN], stable_nxt[KEY_P1_UP]};

  // Conflicts use the post-update levels so a simultaneous up+down rise is suppressed.
  assign p1_conflict = pad_nxt[PadP1Up] & pad_nxt[PadP1Down];
  assign p2_conflict = pad_nxt[PadP2Up] & pad_nxt[PadP2Down];
  assign conflict    = {p2_conflict, p2_conflict, p1_conflict, p1_conflict};

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_SCANS + 1);

  logic [3:0][RepW-1:0] rep_q, rep_d;

  always_comb begin
    rep_d    = rep_q;
    rep_fire = '0;
    if (scan_end) begin
      for (int i = 0; i < 4; i++) begin
        if (pad_rise[i] || !pad_nxt[i]) begin
          rep_d[i] = '0;
        end else if (!conflict[i]) begin
          if (rep_q[i] == RepW'(REPEAT_SCANS - 1)) begin
            rep_fire[i] = 1'b1;
            rep_d[i]    = '0;
          end else begin
            rep_d[i] = rep_q[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`else
  assign rep_fire = '0;
`endif

  always_comb begin
    pad_d      = (pad_rise & ~conflict) | rep_fire;
    key_code_d = key_code_q;
    if (|rise) key_code_d = low_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q     <= '0;
      row_idx_q   <= '0;
      raw_q       <= '0;
      scan_done_q <= 1'b0;
      key_press_q <= 1'b0;
      key_code_q  <= '0;
      pad_q       <= '0;
    end else begin
      dwell_q     <= dwell_d;
      row_idx_q   <= row_idx_d;
      raw_q       <= raw_d;
      scan_done_q <= scan_end;
      key_press_q <= |rise;
      key_code_q  <= key_code_d;
      pad_q       <= pad_d;
    end
  end

  assign row_o       = row_onehot(row_idx_q);
  assign key_state_o = stable;
  assign scan_done_o = scan_done_q;
  assign key_press_o = key_press_q;
  assign key_code_o  = key_code_q;
  assign p1_up_o     = pad_q[PadP1Up];
  assign p1_down_o   = pad_q[PadP1Down];
  assign p2_up_o     = pad_q[PadP2Up];
  assign p2_down_o   = pad_q[PadP2Down];

endmodule
